// File: rtl/mem_wait_state_bridge_if.sv
// Core-side native memory port and model-side strobe port of the wait-state bridge.
// slave = bridge view, master = core/model view.
interface mem_wait_state_bridge_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mdl_la_read;
  logic        mdl_la_write;
  logic [31:0] mdl_la_addr;
  logic [31:0] mdl_la_wdata;
  logic [3:0]  mdl_la_wstrb;
  logic        mdl_instr;
  logic [31:0] mdl_rdata;

  modport slave (
    input  mem_valid, mem_instr, mem_addr,
    input  mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata,
    output mdl_la_read, mdl_la_write,
    output mdl_la_addr, mdl_la_wdata,
    output mdl_la_wstrb, mdl_instr,
    input  mdl_rdata
  );

  modport master (
    output mem_valid, mem_instr, mem_addr,
    output mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata,
    input  mdl_la_read, mdl_la_write,
    input  mdl_la_addr, mdl_la_wdata,
    input  mdl_la_wstrb, mdl_instr,
    output mdl_rdata
  );
endinterface

// File: rtl/mem_wait_state_bridge.sv
// picorv32 mem_valid/mem_ready to single-strobe memory model bridge with wait states.
// MEM_BRIDGE_RAND_WAIT_EN adds LFSR jitter (0..3) to the per-transaction wait count.
module mem_wait_state_bridge #(
  parameter int WAIT_W     = 4,
  parameter int RESET_WAIT = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              resetn,
  mem_wait_state_bridge_if.slave bus,
  input  logic [WAIT_W-1:0] cfg_wait,
  input  logic              cfg_load,
  output logic [CNT_W-1:0]  txn_count,
  output logic              err_valid_drop
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state, state_nx;

  logic [WAIT_W-1:0] wait_reg;
  logic [WAIT_W-1:0] cnt;
  logic [WAIT_W-1:0] cnt_load;
  logic              ready_q;
  logic [31:0]       rdata_q;
  logic              rd_q, wr_q;
  logic [31:0]       addr_q, wdata_q;
  logic [3:0]        wstrb_q;
  logic              instr_q;

  assign bus.mem_ready    = ready_q;
  assign bus.mem_rdata    = rdata_q;
  assign bus.mdl_la_read  = rd_q;
  assign bus.mdl_la_write = wr_q;
  assign bus.mdl_la_addr  = addr_q;
  assign bus.mdl_la_wdata = wdata_q;
  assign bus.mdl_la_wstrb = wstrb_q;
  assign bus.mdl_instr    = instr_q;

`ifdef MEM_BRIDGE_RAND_WAIT_EN
  logic [15:0]     lfsr;
  logic [WAIT_W:0] wsum;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr <= 16'hACE1;
    else lfsr <= {lfsr[14:0],
                  lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // saturate rather than wrap so jitter never shortens the wait
  always_comb begin
    wsum     = {1'b0, wait_reg} + (WAIT_W+1)'(lfsr[1:0]);
    cnt_load = wsum[WAIT_W] ? '1 : wsum[WAIT_W-1:0];
  end
`else
  always_comb cnt_load = wait_reg;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (bus.mem_valid && !ready_q)
          state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:
        if (cnt == '0) state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wait_reg       <= WAIT_W'(RESET_WAIT);
      cnt            <= '0;
      ready_q        <= 1'b0;
      rdata_q        <= '0;
      rd_q           <= 1'b0;
      wr_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      instr_q        <= 1'b0;
      txn_count      <= '0;
      err_valid_drop <= 1'b0;
    end else begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ready_q <= 1'b0;
      if (cfg_load) wait_reg <= cfg_wait;
      unique case (state)
        S_IDLE:
          if (state_nx == S_ISSUE) begin
            addr_q  <= bus.mem_addr;
            wdata_q <= bus.mem_wdata;
            wstrb_q <= bus.mem_wstrb;
            instr_q <= bus.mem_instr;
            rd_q    <= (bus.mem_wstrb == 4'b0000);
            wr_q    <= (bus.mem_wstrb != 4'b0000);
          end
        S_ISSUE: begin
          cnt <= cnt_load;
          if (!bus.mem_valid) err_valid_drop <= 1'b1;
        end
        S_WAIT: begin
          if (!bus.mem_valid) err_valid_drop <= 1'b1;
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            if (wstrb_q == 4'b0000) rdata_q <= bus.mdl_rdata;
            ready_q   <= 1'b1;
            txn_count <= txn_count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wait_state_bridge.sv
// Directed self-checking bench for mem_wait_state_bridge.
// Cycle 0 is the first cycle mem_valid is high; outputs sampled on negedge.
module tb_mem_wait_state_bridge;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] cfg_wait = 4'd0;
  logic       cfg_load = 1'b0;
  logic [15:0] txn_count;
  logic       err_valid_drop;
  int checks = 0;
  int errors = 0;

  mem_wait_state_bridge_if bus();

  mem_wait_state_bridge #(
    .WAIT_W(4), .RESET_WAIT(2), .CNT_W(16)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus),
    .cfg_wait(cfg_wait),
    .cfg_load(cfg_load),
    .txn_count(txn_count),
    .err_valid_drop(err_valid_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_wait(input logic [3:0] w);
    cfg_wait = w;
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
  endtask

  // lat = cycle of mem_ready, -1 if it never came
  task automatic run_txn(
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [3:0]  ws,
    input  logic        ins,
    input  int          cfg_at,
    input  logic [3:0]  cfg_v,
    input  int          drop_at,
    output int          lat,
    output int          rd_n,
    output int          wr_n,
    output int          first_stb
  );
    lat = -1; rd_n = 0; wr_n = 0; first_stb = -1;
    bus.mem_addr  = a;
    bus.mem_wdata = wd;
    bus.mem_wstrb = ws;
    bus.mem_instr = ins;
    for (int k = 0; k < 40; k++) begin
      bus.mem_valid = (k < drop_at);
      cfg_load = (k == cfg_at);
      cfg_wait = cfg_v;
      @(negedge clk);
      if (bus.mdl_la_read) rd_n++;
      if (bus.mdl_la_write) wr_n++;
      if ((bus.mdl_la_read || bus.mdl_la_write) && first_stb < 0)
        first_stb = k;
      if (bus.mem_ready) begin
        lat = k;
        break;
      end
      step();
    end
    step();
    bus.mem_valid = 1'b0;
    cfg_load = 1'b0;
  endtask

  int lat, rdn, wrn, fst;
  int rcnt, scnt;
  int rdy_cyc [3];

  initial begin
    bus.mem_valid = 1'b0;
    bus.mem_instr = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    bus.mdl_rdata = '0;

    // reset state
    #12;
    chk("rst_ready", bus.mem_ready, 0);
    chk("rst_rdata", bus.mem_rdata, 0);
    chk("rst_rd", bus.mdl_la_read, 0);
    chk("rst_wr", bus.mdl_la_write, 0);
    chk("rst_addr", bus.mdl_la_addr, 0);
    chk("rst_txn", txn_count, 0);
    chk("rst_err", err_valid_drop, 0);
    step();
    resetn = 1'b1;
    step();

    // read 0x100 with reset wait count 2
    bus.mdl_rdata = 32'h0000_0013;
    run_txn(32'h100, 0, 4'b0000, 1'b1, -1, 0, 99,
            lat, rdn, wrn, fst);
    chk("rd_lat", lat, 5);
    chk("rd_stb_cyc", fst, 1);
    chk("rd_nrd", rdn, 1);
    chk("rd_nwr", wrn, 0);
    chk("rd_data", bus.mem_rdata, 32'h13);
    chk("rd_addr", bus.mdl_la_addr, 32'h100);
    chk("rd_instr", bus.mdl_instr, 1);
    chk("rd_txn", txn_count, 1);

    // W=0 write, read data must hold
    load_wait(4'd0);
    bus.mdl_rdata = 32'h5555_5555;
    run_txn(32'h10004, 32'hDEAD_BEEF, 4'b0011, 1'b0,
            -1, 0, 99, lat, rdn, wrn, fst);
    chk("wr_lat", lat, 3);
    chk("wr_nwr", wrn, 1);
    chk("wr_nrd", rdn, 0);
    chk("wr_wstrb", bus.mdl_la_wstrb, 4'b0011);
    chk("wr_wdata", bus.mdl_la_wdata, 32'hDEAD_BEEF);
    chk("wr_addr", bus.mdl_la_addr, 32'h10004);
    chk("wr_rdata_hold", bus.mem_rdata, 32'h13);
    chk("wr_txn", txn_count, 2);

    // back-to-back reads, mem_valid held high, W=1
    load_wait(4'd1);
    bus.mdl_rdata = 32'h0BAD_F00D;
    bus.mem_addr  = 32'h200;
    bus.mem_wstrb = 4'b0000;
    bus.mem_valid = 1'b1;
    rcnt = 0; scnt = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (bus.mdl_la_read || bus.mdl_la_write) scnt++;
      if (bus.mem_ready) begin
        if (rcnt < 3) rdy_cyc[rcnt] = k;
        rcnt++;
      end
      step();
      if (k == 14) bus.mem_valid = 1'b0;
    end
    chk("b2b_nready", rcnt, 3);
    chk("b2b_nstb", scnt, 3);
    chk("b2b_first", rdy_cyc[0], 4);
    chk("b2b_gap1", rdy_cyc[1] - rdy_cyc[0], 5);
    chk("b2b_gap2", rdy_cyc[2] - rdy_cyc[1], 5);
    chk("b2b_txn", txn_count, 5);
    chk("b2b_err", err_valid_drop, 0);

    // W=7 loaded during WAIT of a W=1 transaction
    run_txn(32'h300, 0, 4'b0000, 1'b0, 2, 4'd7, 99,
            lat, rdn, wrn, fst);
    chk("cfg_inflight_lat", lat, 4);
    run_txn(32'h304, 0, 4'b0000, 1'b0, -1, 4'd7, 99,
            lat, rdn, wrn, fst);
    chk("cfg_next_lat", lat, 10);
    chk("cfg_txn", txn_count, 7);

    // mem_valid dropped during WAIT
    run_txn(32'h400, 0, 4'b0000, 1'b0, -1, 4'd7, 3,
            lat, rdn, wrn, fst);
    chk("drop_lat", lat, 10);
    chk("drop_err", err_valid_drop, 1);
    repeat (3) step();
    chk("drop_err_sticky", err_valid_drop, 1);
    resetn = 1'b0;
    #1;
    chk("drop_err_rst", err_valid_drop, 0);
    step();
    resetn = 1'b1;
    step();

    // reset wait count restored; then reset during ISSUE
    bus.mdl_rdata = 32'hA5A5_A5A5;
    run_txn(32'h500, 0, 4'b0000, 1'b0, -1, 0, 99,
            lat, rdn, wrn, fst);
    chk("rw_lat", lat, 5);
    chk("rw_rdata", bus.mem_rdata, 32'hA5A5_A5A5);
    bus.mem_addr  = 32'h600;
    bus.mem_wstrb = 4'b0000;
    bus.mem_valid = 1'b1;
    step();
    chk("iss_rd", bus.mdl_la_read, 1);
    #1 resetn = 1'b0;
    #1;
    chk("iss_rst_rd", bus.mdl_la_read, 0);
    chk("iss_rst_ready", bus.mem_ready, 0);
    chk("iss_rst_txn", txn_count, 0);
    chk("iss_rst_rdata", bus.mem_rdata, 0);
    chk("iss_rst_addr", bus.mdl_la_addr, 0);
    bus.mem_valid = 1'b0;
    step();
    resetn = 1'b1;
    scnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.mdl_la_read || bus.mdl_la_write || bus.mem_ready)
        scnt++;
    end
    chk("no_retry", scnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
